// File: rtl/pattern_gen.sv
// Programmable pattern generator: up/down counter, Fibonacci LFSR or walking one,
// advanced by a prescaled tick and handed off over a valid/ready output port.
module pattern_gen #(
    parameter int unsigned      WIDTH = 8,
    parameter int unsigned      DIV_W = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8)
) (
    input  logic              ref_clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  div,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wrap,
    output logic              overrun
);

    localparam int unsigned MODE_UP   = 0;
    localparam int unsigned MODE_DOWN = 1;
    localparam int unsigned MODE_LFSR = 2;
    localparam int unsigned MODE_WALK = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [DIV_W-1:0]   cnt_q;
    logic [DIV_W-1:0]   cnt_d;
    logic [WIDTH-1:0]   out_d;
    logic               out_valid_d;
    logic               wrap_d;
    logic               overrun_d;

    logic [WIDTH-1:0]   lfsr_pat;
    logic [WIDTH-1:0]   nxt_pat;
    logic               nxt_wrap;
    logic               tick;
    logic               xfer;
    logic               step;
    logic               drop;

    // Prescaler compare and handshake qualifiers
    always_comb begin
        tick = en && (state_q != IDLE) && (cnt_q == div);
        xfer = out_valid && out_ready;
        // A step may only replace a sample that is absent or leaving this cycle
        step = tick && (!out_valid || out_ready);
        drop = tick && out_valid && !out_ready;
    end

    // Next pattern value and wrap flag for the selected mode
    always_comb begin
        nxt_pat  = out;
        nxt_wrap = 1'b0;
        lfsr_pat = {out[WIDTH-2:0], ^(out & TAPS)};
        case (mode)
            2'(MODE_UP): begin
                nxt_pat  = out + WIDTH'(1);
                nxt_wrap = &out;
            end
            2'(MODE_DOWN): begin
                nxt_pat  = out - WIDTH'(1);
                nxt_wrap = ~|out;
            end
            2'(MODE_LFSR): begin
                // All-zero is the LFSR lock-up state; restart the sequence at 1
                if (out == '0) begin
                    nxt_pat  = WIDTH'(1);
                end else begin
                    nxt_pat  = lfsr_pat;
                end
                nxt_wrap = (nxt_pat == WIDTH'(1));
            end
            2'(MODE_WALK): begin
                // Anything other than a single set bit is re-seeded without a wrap
                if ($onehot(out)) begin
                    nxt_pat  = {out[WIDTH-2:0], out[WIDTH-1]};
                    nxt_wrap = out[WIDTH-1];
                end else begin
                    nxt_pat  = WIDTH'(1);
                    nxt_wrap = 1'b0;
                end
            end
            default: begin
                nxt_pat  = out;
                nxt_wrap = 1'b0;
            end
        endcase
    end

    // Next-state, prescaler and output-register logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_d       = out;
        out_valid_d = out_valid;
        wrap_d      = 1'b0;
        overrun_d   = overrun;

        if (xfer) begin
            out_valid_d = 1'b0;
        end

        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    state_d = RUN;
                end
                RUN, STALL: begin
                    // Count above a freshly lowered div also returns to 0, without a tick
                    cnt_d = (cnt_q >= div) ? '0 : cnt_q + DIV_W'(1);
                    if (step) begin
                        out_d       = nxt_pat;
                        out_valid_d = 1'b1;
                        wrap_d      = nxt_wrap;
                        state_d     = RUN;
                    end else if (drop) begin
                        overrun_d = 1'b1;
                        state_d   = STALL;
                    end else if (xfer) begin
                        state_d = RUN;
                    end else if (out_valid) begin
                        state_d = STALL;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Preset wins over any step and silently replaces a pending sample
        if (load) begin
            out_d       = load_val;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            wrap_d      = 1'b0;
            overrun_d   = 1'b0;
            if (en) begin
                state_d = RUN;
            end
        end
    end

    // State and output registers
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out       <= out_d;
            out_valid <= out_valid_d;
            wrap      <= wrap_d;
            overrun   <= overrun_d;
        end
    end

endmodule

// File: tb/tb_pattern_gen.sv
// Scoreboard bench for pattern_gen: directed stimulus pushes expected samples,
// a negedge monitor pops and compares on every output transfer.
module tb_pattern_gen;

    logic        ref_clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [15:0] div;
    logic        load;
    logic [7:0]  load_val;
    logic [7:0]  out;
    logic        out_valid;
    logic        out_ready;
    logic        wrap;
    logic        overrun;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [8:0]  sb[$];   // {wrap, out}

    pattern_gen #(.WIDTH(8), .DIV_W(16), .TAPS(8'hB8)) dut (
        .ref_clk   (ref_clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .div       (div),
        .load      (load),
        .load_val  (load_val),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .wrap      (wrap),
        .overrun   (overrun)
    );

    always #5 ref_clk = ~ref_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] v, input logic w);
        sb.push_back({w, v});
    endtask

    // Monitor: every accepted sample must match the head of the scoreboard
    always @(negedge ref_clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_sample: got out=%0h wrap=%0b with nothing expected", out, wrap);
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                check("sample_out", 32'(out), 32'(e[7:0]));
                check("sample_wrap", 32'(wrap), 32'(e[8]));
            end
        end
    end

    task step_clk();
        @(posedge ref_clk);
        #1;
    endtask

    task pulse_load(input logic [7:0] v);
        load     = 1'b1;
        load_val = v;
        step_clk();
        load     = 1'b0;
    endtask

    task wait_empty(input int limit);
        int g;
        g = 0;
        while (sb.size() != 0 && g < limit) begin
            @(negedge ref_clk);
            #1;
            g++;
        end
        check("drain_queue", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task count_until_valid(output int n);
        n = 0;
        do begin
            step_clk();
            n++;
        end while (!out_valid && n < 50);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        logic [7:0] v;
        logic [7:0] hand [8];

        rst = 1'b1; en = 1'b0; mode = 2'd0; div = 16'd0;
        load = 1'b0; load_val = 8'h00; out_ready = 1'b1;
        repeat (3) step_clk();
        check("reset_out", 32'(out), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_wrap", 32'(wrap), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);

        // Up-count, div=2, full wrap from 255 to 0
        rst  = 1'b0;
        mode = 2'd0;
        div  = 16'd2;
        for (int i = 1; i < 256; i++) push(8'(i), 1'b0);
        push(8'h00, 1'b1);
        en = 1'b1;
        count_until_valid(n);
        check("first_step_latency", 32'(n), 32'd4);
        wait_empty(1000);
        en = 1'b0;
        step_clk();
        check("wrap_pulse_width", 32'(wrap), 32'd0);
        check("idle_hold_out", 32'(out), 32'h00);

        // Walking one seeded from a non-one-hot load
        mode = 2'd3;
        div  = 16'd0;
        push(8'h05, 1'b0);
        pulse_load(8'h05);
        en = 1'b1;
        for (int i = 0; i < 8; i++) push(8'(1 << i), 1'b0);
        push(8'h01, 1'b1);
        wait_empty(100);
        en = 1'b0;
        step_clk();

        // LFSR full period from 0x01, then lock-up escape from 0x00
        mode = 2'd2;
        push(8'h01, 1'b0);
        pulse_load(8'h01);
        en = 1'b1;
        hand = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E, 8'h1C};
        for (int i = 0; i < 8; i++) push(hand[i], 1'b0);
        v = 8'h1C;
        for (int i = 9; i <= 255; i++) begin
            v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
            push(v, v == 8'h01);
        end
        wait_empty(400);
        en = 1'b0;
        step_clk();
        push(8'h00, 1'b0);
        pulse_load(8'h00);
        en = 1'b1;
        push(8'h01, 1'b1);
        wait_empty(20);
        en = 1'b0;
        step_clk();

        // Back-pressure: stall, overrun, resume, sticky until load
        mode = 2'd0;
        div  = 16'd0;
        push(8'h10, 1'b0);
        pulse_load(8'h10);
        step_clk();
        out_ready = 1'b0;
        en = 1'b1;
        push(8'h11, 1'b0);
        step_clk();
        step_clk();
        check("first_tick_out", 32'(out), 32'h11);
        check("first_tick_overrun", 32'(overrun), 32'd0);
        step_clk();
        check("second_tick_overrun", 32'(overrun), 32'd1);
        check("second_tick_frozen", 32'(out), 32'h11);
        step_clk();
        step_clk();
        check("stall_frozen", 32'(out), 32'h11);
        check("stall_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        push(8'h12, 1'b0);
        push(8'h13, 1'b0);
        push(8'h14, 1'b0);
        wait_empty(20);
        en = 1'b0;
        step_clk();
        check("overrun_sticky", 32'(overrun), 32'd1);
        push(8'h00, 1'b0);
        pulse_load(8'h00);
        check("overrun_clear_on_load", 32'(overrun), 32'd0);
        step_clk();

        // Down-count from 0 with tick and transfer in the same cycle
        mode = 2'd1;
        push(8'h00, 1'b0);
        load     = 1'b1;
        load_val = 8'h00;
        en       = 1'b1;
        step_clk();
        load = 1'b0;
        push(8'hFF, 1'b1);
        push(8'hFE, 1'b0);
        step_clk();
        check("down_wrap_out", 32'(out), 32'hFF);
        check("down_wrap_valid", 32'(out_valid), 32'd1);
        check("down_wrap_overrun", 32'(overrun), 32'd0);
        wait_empty(20);
        en = 1'b0;
        step_clk();

        // Load vs tick priority and prescaler restart, div=3
        mode = 2'd0;
        div  = 16'd3;
        push(8'h40, 1'b0);
        pulse_load(8'h40);
        en = 1'b1;
        push(8'h41, 1'b0);
        count_until_valid(n);
        check("latency_div3", 32'(n), 32'd5);
        step_clk();
        step_clk();
        step_clk();
        load     = 1'b1;
        load_val = 8'h80;
        push(8'h80, 1'b0);
        push(8'h81, 1'b0);
        step_clk();
        load = 1'b0;
        check("load_beats_tick", 32'(out), 32'h80);
        count_until_valid(n);
        check("reload_latency", 32'(n), 32'd4);
        step_clk();
        step_clk();
        load     = 1'b1;
        load_val = 8'h20;
        push(8'h20, 1'b0);
        push(8'h21, 1'b0);
        step_clk();
        load = 1'b0;
        count_until_valid(n);
        check("load_resets_prescaler", 32'(n), 32'd4);
        check("load_resets_out", 32'(out), 32'h21);

        // Asynchronous reset mid-count, then restart latency
        step_clk();
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_out", 32'(out), 32'd0);
        check("async_reset_valid", 32'(out_valid), 32'd0);
        check("async_reset_wrap", 32'(wrap), 32'd0);
        check("async_reset_overrun", 32'(overrun), 32'd0);
        sb.delete();
        step_clk();
        step_clk();
        rst = 1'b0;
        push(8'h01, 1'b0);
        count_until_valid(n);
        check("post_reset_latency", 32'(n), 32'd5);
        wait_empty(20);
        en = 1'b0;
        step_clk();

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pattern_gen.md
PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 Parameter WIDTH, default 8: pattern/output width; legal range 2..64.
REQ-002 Parameter DIV_W, default 16: prescaler divisor width.
REQ-003 Parameter TAPS, default 8'hB8: LFSR feedback tap mask, WIDTH bits; bit i set means out[i] is XORed into the feedback bit.
REQ-004 ref_clk  in  1  sole clock; all logic is rising-edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 en  in  1  run enable.
REQ-007 mode  in  2  0 up-count, 1 down-count, 2 LFSR, 3 walking-one.
REQ-008 div  in  DIV_W  prescaler: one step every div+1 cycles.
REQ-009 load  in  1  synchronous preset strobe.
REQ-010 load_val  in  WIDTH  preset value.
REQ-011 out  out  WIDTH  current pattern value (registered).
REQ-012 out_valid  out  1  out holds an unconsumed sample.
REQ-013 out_ready  in  1  consumer accept; a transfer occurs when out_valid and out_ready are both 1.
REQ-014 wrap  out  1  one-cycle pulse on pattern wrap.
REQ-015 overrun  out  1  sticky: a step was dropped because the previous sample was not consumed.

Function
REQ-016 The prescaler SHALL count 0..div while en=1 and SHALL assert an internal tick in the cycle it equals div, then return to 0; div=0 SHALL tick every cycle.
REQ-017 A change of div SHALL take effect at the next prescaler compare; a count already above the new div SHALL wrap to 0 on the next cycle without a tick.
REQ-018 The FSM SHALL have states IDLE, RUN and STALL.
REQ-019 IDLE: prescaler held at 0; go to RUN when en=1.
REQ-020 RUN, on tick: advance out per mode; set out_valid=1 the same edge.
REQ-021 RUN SHALL go to STALL when out_valid=1, out_ready=0 and no tick occurs.
REQ-022 STALL, on tick: out not advanced; set overrun=1; stay in STALL.
REQ-023 STALL SHALL return to RUN on the transfer edge.
REQ-024 A transfer without a simultaneous step SHALL clear out_valid the following cycle.
REQ-025 Transfer and tick in the same cycle SHALL advance out and keep out_valid=1, with no overrun.
REQ-026 en=0 in any state SHALL go to IDLE and clear the prescaler; out and out_valid SHALL hold, and a pending sample stays valid until transferred.
REQ-027 Mode 0 SHALL compute out+1 modulo 2^WIDTH; wrap=1 on the all-ones -> 0 step.
REQ-028 Mode 1 SHALL compute out-1 modulo 2^WIDTH; wrap=1 on the 0 -> all-ones step.
REQ-029 Mode 2 SHALL shift left, with LSB = XOR of (out AND TAPS); wrap=1 when the new value equals 1.
REQ-030 Mode 2 from out=0 SHALL force the next value to 1 (lock-up escape).
REQ-031 Mode 3 SHALL rotate left by one; wrap=1 on the MSB -> LSB step.
REQ-032 Mode 3 from a value without exactly one bit set SHALL force the next value to 1, with wrap=0.
REQ-033 A mode change SHALL take effect at the next tick, applied to the current out.
REQ-034 load=1 SHALL have priority over tick: out=load_val, out_valid=1, prescaler=0, wrap=0; an un-transferred previous sample is overwritten without setting overrun.
REQ-035 load SHALL act in every state, including IDLE.
REQ-036 overrun SHALL clear only on rst or load.
REQ-037 Latency: out SHALL update on the same edge that samples tick or load.

Reset
REQ-038 rst=1 SHALL asynchronously force state=IDLE, prescaler=0, out=0, out_valid=0, wrap=0, overrun=0.
REQ-039 Reset asserted mid-operation SHALL discard any pending sample and any prescaler count.
REQ-040 After rst deasserts, the first step SHALL occur div+1 cycles after en is seen high.

Verification
REQ-041 WIDTH=8, mode 0, div=2, out_ready=1, en=1 -> out 1,2,3... every 3 cycles; after 255 the value 0 with wrap=1 for one cycle.
REQ-042 mode 2, TAPS=8'hB8, load_val=0x01 -> sequence period 255; out never 0; wrap at each return to 1; load_val=0 -> next value 1.
REQ-043 mode 0, div=0, out_ready=0 for 4 cycles -> out frozen at its first new value; overrun=1 from the 2nd tick; set out_ready=1 -> transfer, counting resumes, overrun stays 1 until load.
REQ-044 mode 3, load with load_val=0x05 -> next step out=0x01, wrap=0; then 0x02, 0x04 ... 0x80, then 0x01 with wrap=1.
REQ-045 load and tick in the same cycle -> out=load_val, prescaler=0, no advance; rst pulsed mid-count -> all outputs 0 immediately, without waiting for a ref_clk edge.
REQ-046 mode 1 from 0x00 with tick and out_ready=1 in the same cycle -> out=0xFF, wrap=1, out_valid remains 1, overrun=0.
